// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer: display state codes, FSM encoding
// and the settings default.
package game_flow_ctrl_pkg;

    localparam logic [1:0] ST_WELCOME  = 2'd0;
    localparam logic [1:0] ST_MAP      = 2'd1;
    localparam logic [1:0] ST_WIN      = 2'd2;
    localparam logic [1:0] ST_LOSE     = 2'd3;

    localparam logic [4:0] DEFAULT_NUM = 5'd11;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_GEN,
        FSM_PLAY,
        FSM_WIN,
        FSM_LOSE
    } fsm_t;

    // GEN and PLAY both show the map, so the display path sees one code for them.
    function automatic logic [1:0] state_code(input fsm_t s);
        case (s)
            FSM_GEN, FSM_PLAY: state_code = ST_MAP;
            FSM_WIN:           state_code = ST_WIN;
            FSM_LOSE:          state_code = ST_LOSE;
            default:           state_code = ST_WELCOME;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_sec_tick.sv
// Countdown-second divider: one-cycle tick every TICK_DIV clocks while clr is low.
// clr holds the count at zero so the first second after release is a full one.
module game_flow_ctrl_sec_tick #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_sys,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = ~clr && (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: welcome -> maze build handshake -> timed round ->
// win/lose, with edge-detected Enter/Esc keys and a saturating round timer.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned SEC_PER_ROW = 6,
    parameter int unsigned TIME_W      = 8
) (
    input  logic              clk,
    input  logic              rst_sys,
    input  logic              key_enter,
    input  logic              key_esc,
    input  logic [4:0]        sel_num,
    input  logic [2:0]        sel_level,
    input  logic              gen_done,
    input  logic              player_at_exit,
    output logic [1:0]        state,
    output logic              gen_req,
    output logic [4:0]        cfg_num,
    output logic [2:0]        cfg_level,
    output logic              play_en,
    output logic [TIME_W-1:0] time_left
);

    localparam int unsigned       PROD_W   = 5 + 32;
    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    fsm_t              fsm, fsm_nxt;
    logic              enter_q, esc_q;
    logic              enter_edge, esc_edge;
    logic              tick;
    logic [PROD_W-1:0] limit_full;
    logic [TIME_W-1:0] limit_sat;
    logic [TIME_W-1:0] time_nxt;
    logic [4:0]        num_nxt;
    logic [2:0]        level_nxt;

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            enter_q <= 1'b0;
            esc_q   <= 1'b0;
        end else begin
            enter_q <= key_enter;
            esc_q   <= key_esc;
        end
    end

    assign enter_edge = key_enter & ~enter_q;
    assign esc_edge   = key_esc & ~esc_q;

    game_flow_ctrl_sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk     (clk),
        .rst_sys (rst_sys),
        .clr     (fsm != FSM_PLAY),
        .tick    (tick)
    );

    // Full-width product so large mazes clamp to the counter's max, not wrap.
    assign limit_full = PROD_W'(cfg_num) * PROD_W'(SEC_PER_ROW);
    assign limit_sat  = (limit_full > PROD_W'(TIME_MAX)) ? TIME_MAX
                                                         : limit_full[TIME_W-1:0];

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys)
            fsm <= FSM_IDLE;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        time_nxt  = time_left;
        num_nxt   = cfg_num;
        level_nxt = cfg_level;
        case (fsm)
            FSM_IDLE: begin
                if (enter_edge) begin
                    num_nxt   = sel_num;
                    level_nxt = sel_level;
                    fsm_nxt   = FSM_GEN;
                end
            end
            FSM_GEN: begin
                if (esc_edge) begin
                    fsm_nxt  = FSM_IDLE;
                    time_nxt = '0;
                end else if (gen_done) begin
                    fsm_nxt  = FSM_PLAY;
                    time_nxt = limit_sat;
                end
            end
            FSM_PLAY: begin
                // Reaching the exit wins even on the final tick; time stays put.
                if (player_at_exit) begin
                    fsm_nxt = FSM_WIN;
                end else if (esc_edge) begin
                    fsm_nxt  = FSM_IDLE;
                    time_nxt = '0;
                end else if (tick) begin
                    if (time_left <= TIME_W'(1)) begin
                        fsm_nxt  = FSM_LOSE;
                        time_nxt = '0;
                    end else begin
                        time_nxt = time_left - 1'b1;
                    end
                end
            end
            FSM_WIN, FSM_LOSE: begin
                if (enter_edge || esc_edge) begin
                    fsm_nxt  = FSM_IDLE;
                    time_nxt = '0;
                end
            end
            default: begin
                fsm_nxt  = FSM_IDLE;
                time_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state     <= ST_WELCOME;
            gen_req   <= 1'b0;
            play_en   <= 1'b0;
            cfg_num   <= DEFAULT_NUM;
            cfg_level <= 3'd0;
            time_left <= '0;
        end else begin
            state     <= state_code(fsm_nxt);
            gen_req   <= (fsm_nxt == FSM_GEN);
            play_en   <= (fsm_nxt == FSM_PLAY);
            cfg_num   <= num_nxt;
            cfg_level <= level_nxt;
            time_left <= time_nxt;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (6 and 20 s/row) checked every cycle
// against a round-level model, plus directed scenarios and random traffic.
module tb_game_flow_ctrl;

    localparam int TDIV = 4;
    localparam int SPR0 = 6;
    localparam int SPR1 = 20;

    logic       clk = 1'b0;
    logic       rst_sys;
    logic       key_enter, key_esc, gen_done, player_at_exit;
    logic [4:0] sel_num;
    logic [2:0] sel_level;

    logic [1:0] state_o     [2];
    logic       gen_req_o   [2];
    logic [4:0] cfg_num_o   [2];
    logic [2:0] cfg_level_o [2];
    logic       play_en_o   [2];
    logic [7:0] time_left_o [2];

    always #5 clk = ~clk;

    game_flow_ctrl #(.TICK_DIV(TDIV), .SEC_PER_ROW(SPR0), .TIME_W(8)) dut0 (
        .clk(clk), .rst_sys(rst_sys), .key_enter(key_enter), .key_esc(key_esc),
        .sel_num(sel_num), .sel_level(sel_level), .gen_done(gen_done),
        .player_at_exit(player_at_exit), .state(state_o[0]), .gen_req(gen_req_o[0]),
        .cfg_num(cfg_num_o[0]), .cfg_level(cfg_level_o[0]), .play_en(play_en_o[0]),
        .time_left(time_left_o[0])
    );

    game_flow_ctrl #(.TICK_DIV(TDIV), .SEC_PER_ROW(SPR1), .TIME_W(8)) dut1 (
        .clk(clk), .rst_sys(rst_sys), .key_enter(key_enter), .key_esc(key_esc),
        .sel_num(sel_num), .sel_level(sel_level), .gen_done(gen_done),
        .player_at_exit(player_at_exit), .state(state_o[1]), .gen_req(gen_req_o[1]),
        .cfg_num(cfg_num_o[1]), .cfg_level(cfg_level_o[1]), .play_en(play_en_o[1]),
        .time_left(time_left_o[1])
    );

    // Model: shown screen, pending build, seconds left, cycles into current second.
    typedef struct {
        int st;
        bit gen;
        int tl;
        int cyc;
        int cnum;
        int clvl;
    } mdl_t;

    mdl_t m [2];
    bit   pe, ps;
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].st = 0; m[i].gen = 0; m[i].tl = 0; m[i].cyc = 0;
            m[i].cnum = 11; m[i].clvl = 0;
        end
        pe = 0;
        ps = 0;
    endtask

    task automatic model_step();
        bit ee, se, tk;
        int lim;
        ee = key_enter && !pe;
        se = key_esc && !ps;
        for (int i = 0; i < 2; i++) begin
            if (m[i].st == 0) begin
                if (ee) begin
                    m[i].cnum = sel_num; m[i].clvl = sel_level;
                    m[i].gen = 1; m[i].st = 1;
                end
            end else if (m[i].st == 1 && m[i].gen) begin
                if (se) begin
                    m[i].st = 0; m[i].gen = 0; m[i].tl = 0;
                end else if (gen_done) begin
                    lim = m[i].cnum * ((i == 0) ? SPR0 : SPR1);
                    m[i].gen = 0;
                    m[i].tl  = (lim > 255) ? 255 : lim;
                    m[i].cyc = 0;
                end
            end else if (m[i].st == 1) begin
                m[i].cyc++;
                tk = (m[i].cyc == TDIV);
                if (tk) m[i].cyc = 0;
                if (player_at_exit) m[i].st = 2;
                else if (se) begin
                    m[i].st = 0; m[i].tl = 0;
                end else if (tk) begin
                    m[i].tl--;
                    if (m[i].tl <= 0) begin
                        m[i].tl = 0; m[i].st = 3;
                    end
                end
            end else if (ee || se) begin
                m[i].st = 0; m[i].tl = 0;
            end
        end
        pe = key_enter;
        ps = key_esc;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.d%0d.state", tag, i), 32'(state_o[i]), m[i].st);
            check($sformatf("%s.d%0d.gen_req", tag, i), 32'(gen_req_o[i]), 32'(m[i].gen));
            check($sformatf("%s.d%0d.play_en", tag, i), 32'(play_en_o[i]),
                  32'(m[i].st == 1 && !m[i].gen));
            check($sformatf("%s.d%0d.cfg_num", tag, i), 32'(cfg_num_o[i]), m[i].cnum);
            check($sformatf("%s.d%0d.cfg_level", tag, i), 32'(cfg_level_o[i]), m[i].clvl);
            check($sformatf("%s.d%0d.time_left", tag, i), 32'(time_left_o[i]), m[i].tl);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_sys = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.d%0d.rst_state", tag, i), 32'(state_o[i]), 0);
            check($sformatf("%s.d%0d.rst_gen_req", tag, i), 32'(gen_req_o[i]), 0);
            check($sformatf("%s.d%0d.rst_play_en", tag, i), 32'(play_en_o[i]), 0);
            check($sformatf("%s.d%0d.rst_cfg_num", tag, i), 32'(cfg_num_o[i]), 11);
            check($sformatf("%s.d%0d.rst_cfg_level", tag, i), 32'(cfg_level_o[i]), 0);
            check($sformatf("%s.d%0d.rst_time_left", tag, i), 32'(time_left_o[i]), 0);
        end
        key_enter = 0; key_esc = 0; gen_done = 0; player_at_exit = 0;
        @(negedge clk);
        rst_sys = 1'b0;
    endtask

    task automatic start_round(input int num, input int lvl, input string tag);
        sel_num = 5'(num); sel_level = 3'(lvl);
        key_enter = 1; step(tag);
        key_enter = 0; step(tag);
        gen_done = 1; step(tag);
        gen_done = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int gen_entries;
        bit prev_req;
        bit found;

        rst_sys = 1; key_enter = 0; key_esc = 0; gen_done = 0; player_at_exit = 0;
        sel_num = 5'd5; sel_level = 3'd0;
        #2;
        do_reset("t0");

        // Round start: latch 13/3, build handshake, 78 s budget.
        sel_num = 5'd13; sel_level = 3'd3;
        key_enter = 1; step("t1");
        key_enter = 0;
        check("t1.state_map", 32'(state_o[0]), 1);
        check("t1.gen_req", 32'(gen_req_o[0]), 1);
        check("t1.cfg_num", 32'(cfg_num_o[0]), 13);
        check("t1.cfg_level", 32'(cfg_level_o[0]), 3);
        sel_num = 5'd7; sel_level = 3'd6;
        step("t1"); step("t1");
        gen_done = 1; step("t1");
        gen_done = 0;
        check("t1.gen_req_drop", 32'(gen_req_o[0]), 0);
        check("t1.time_78", 32'(time_left_o[0]), 78);
        check("t1.play_en", 32'(play_en_o[0]), 1);
        check("t1.cfg_held", 32'(cfg_num_o[0]), 13);
        step("t1"); step("t1"); step("t1");
        check("t1.full_first_sec", 32'(time_left_o[0]), 78);
        step("t1");
        check("t1.first_tick", 32'(time_left_o[0]), 77);

        // Run dut0 to timeout.
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            step("t4");
            if (m[0].st == 3) found = 1;
        end
        check("t4.lose_reached", 32'(found), 1);
        check("t4.lose_state", 32'(state_o[0]), 3);
        check("t4.lose_time", 32'(time_left_o[0]), 0);
        check("t4.lose_play_en", 32'(play_en_o[0]), 0);

        // Saturation: 19*6=114, 19*20=380 -> 255.
        do_reset("t3");
        start_round(19, 2, "t3");
        check("t3.d0_time", 32'(time_left_o[0]), 114);
        check("t3.d1_sat", 32'(time_left_o[1]), 255);

        // Held Enter: one build, and the held level does not leave WIN.
        do_reset("t2");
        sel_num = 5'd7; sel_level = 3'd1;
        gen_entries = 0; prev_req = 0;
        key_enter = 1;
        for (int k = 0; k < 20; k++) begin
            gen_done = (k == 3);
            player_at_exit = (k == 8);
            step("t2");
            if (gen_req_o[0] && !prev_req) gen_entries++;
            prev_req = gen_req_o[0];
        end
        gen_done = 0; player_at_exit = 0;
        check("t2.one_gen", gen_entries, 1);
        check("t2.stays_win", 32'(state_o[0]), 2);
        key_enter = 0; step("t2");
        key_enter = 1; step("t2");
        key_enter = 0;
        check("t2.back_idle", 32'(state_o[0]), 0);
        check("t2.idle_time", 32'(time_left_o[0]), 0);

        // Exit on the final tick wins with time frozen at 1.
        do_reset("t5");
        start_round(5, 0, "t5");
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m[0].st == 1 && m[0].tl == 1 && m[0].cyc == TDIV - 1) found = 1;
            else step("t5");
        end
        check("t5.reached", 32'(found), 1);
        player_at_exit = 1; step("t5");
        player_at_exit = 0;
        check("t5.win", 32'(state_o[0]), 2);
        check("t5.time_kept", 32'(time_left_o[0]), 1);
        step("t5");

        // Esc aborts the build; a late gen_done is ignored.
        do_reset("t6");
        sel_num = 5'd9; sel_level = 3'd5;
        key_enter = 1; step("t6");
        key_enter = 0; step("t6");
        key_esc = 1; step("t6");
        key_esc = 0;
        check("t6.abort_state", 32'(state_o[0]), 0);
        check("t6.abort_req", 32'(gen_req_o[0]), 0);
        step("t6");
        gen_done = 1; step("t6");
        gen_done = 0; step("t6");
        check("t6.late_done_state", 32'(state_o[0]), 0);
        check("t6.late_done_req", 32'(gen_req_o[0]), 0);

        // Reset mid-round.
        start_round(15, 4, "t6");
        for (int k = 0; k < 6; k++) step("t6");
        check("t6.in_play", 32'(play_en_o[0]), 1);
        do_reset("t6r");

        // Random traffic.
        for (int k = 0; k < 900; k++) begin
            key_enter      = ($urandom_range(0, 9) == 0);
            key_esc        = ($urandom_range(0, 29) == 0);
            gen_done       = ($urandom_range(0, 3) == 0);
            player_at_exit = ($urandom_range(0, 39) == 0);
            sel_num        = 5'(5 + 2 * $urandom_range(0, 7));
            sel_level      = 3'($urandom_range(0, 7));
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
